// File: rtl/conv_window_streamer.sv
// rtl/conv_window_streamer.sv - multi-channel KSIZE x KSIZE sliding-window generator with stride 1/2
module conv_window_streamer #(
    parameter int BITSIZE   = 14,
    parameter int CHANNELS  = 16,
    parameter int KSIZE     = 3,
    parameter int MAX_WIDTH = 114
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic                                     flush,
    input  logic [7:0]                               cfg_width,
    input  logic [7:0]                               cfg_height,
    input  logic                                     cfg_stride2,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [CHANNELS*BITSIZE-1:0]              in_pixels,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [CHANNELS*KSIZE*KSIZE*BITSIZE-1:0]  out_window,
    output logic                                     frame_done,
    output logic                                     cfg_err,
    output logic                                     busy
);
    localparam int PW = CHANNELS * BITSIZE;
    localparam int KK = KSIZE * KSIZE;
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [7:0] K_M1 = 8'(KSIZE - 1);
    localparam logic [8:0] K_9  = 9'(KSIZE);
    localparam logic [8:0] MW_9 = 9'(MAX_WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 w_m1_q, h_m1_q;
    logic                       stride2_q;
    logic [7:0]                 col_q, row_q;
    logic                       rx_done_q;
    logic [CHANNELS*KK*BITSIZE-1:0] win_q;
    logic [PW-1:0]              lb [KSIZE-1][MAX_WIDTH];
    logic [PW-1:0]              new_col [KSIZE];
    logic [AW-1:0]              col_idx;
    logic                       cfg_ok, start_ok, start_bad, beat;
    logic                       last_col, last_row, phase_ok, completes;

    assign cfg_ok = ({1'b0, cfg_width} >= K_9) && ({1'b0, cfg_width} <= MW_9)
                 && ({1'b0, cfg_height} >= K_9);
    assign start_ok  = (state_q == IDLE) && start && !flush && cfg_ok;
    assign start_bad = (state_q == IDLE) && start && !flush && !cfg_ok;

    assign in_ready   = (state_q == RUN) && !rx_done_q && (!out_valid || out_ready);
    assign beat       = in_valid && in_ready;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign out_window = win_q;

    assign col_idx  = col_q[AW-1:0];
    assign last_col = (col_q == w_m1_q);
    assign last_row = (row_q == h_m1_q);
    // (row - (KSIZE-1)) is even exactly when row shares the parity of KSIZE-1
    assign phase_ok  = !stride2_q || ((row_q[0] == K_M1[0]) && (col_q[0] == K_M1[0]));
    assign completes = (row_q >= K_M1) && (col_q >= K_M1) && phase_ok;

    // Column entering the window: oldest row from the deepest line buffer, newest is the live pixel
    always_comb begin
        for (int r = 0; r < KSIZE - 1; r++) begin
            new_col[r] = lb[KSIZE - 2 - r][col_idx];
        end
        new_col[KSIZE - 1] = in_pixels;
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            lb[0][col_idx] <= in_pixels;
            for (int j = 1; j < KSIZE - 1; j++) begin
                lb[j][col_idx] <= lb[j - 1][col_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (beat) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int r = 0; r < KSIZE; r++) begin
                    for (int k = 0; k < KSIZE - 1; k++) begin
                        win_q[(c*KK + r*KSIZE + k)*BITSIZE +: BITSIZE]
                            <= win_q[(c*KK + r*KSIZE + k + 1)*BITSIZE +: BITSIZE];
                    end
                    win_q[(c*KK + r*KSIZE + KSIZE - 1)*BITSIZE +: BITSIZE]
                        <= new_col[r][c*BITSIZE +: BITSIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (rx_done_q && (!out_valid || out_ready)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_m1_q    <= '0;
            h_m1_q    <= '0;
            stride2_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            rx_done_q <= 1'b0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= start_bad;
            if (flush) begin
                col_q     <= '0;
                row_q     <= '0;
                rx_done_q <= 1'b0;
                out_valid <= 1'b0;
            end else if (start_ok) begin
                w_m1_q    <= cfg_width - 8'd1;
                h_m1_q    <= cfg_height - 8'd1;
                stride2_q <= cfg_stride2;
                col_q     <= '0;
                row_q     <= '0;
                rx_done_q <= 1'b0;
                out_valid <= 1'b0;
            end else if (beat) begin
                out_valid <= completes;
                if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                        rx_done_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 8'd1;
                    end
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_streamer.sv
// tb/tb_conv_window_streamer.sv - scoreboard bench for conv_window_streamer (KSIZE 3 and 5 instances)
module tb_conv_window_streamer;
    localparam int B   = 14;
    localparam int CH  = 16;
    localparam int K   = 3;
    localparam int MW  = 114;
    localparam int PW  = CH * B;
    localparam int WW  = CH * K * K * B;
    localparam int CH5 = 2;
    localparam int K5  = 5;
    localparam int PW5 = CH5 * B;
    localparam int WW5 = CH5 * K5 * K5 * B;

    typedef struct {
        logic [WW-1:0] win;
        int            idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 0, flush = 0, cfg_stride2 = 0, in_valid = 0, out_ready = 1;
    logic [7:0]    cfg_width = 0, cfg_height = 0;
    logic [PW-1:0] in_pixels = '0;
    logic          in_ready, out_valid, frame_done, cfg_err, busy;
    logic [WW-1:0] out_window;

    logic           start5 = 0, flush5 = 0, stride5 = 0, in_valid5 = 0, out_ready5 = 1;
    logic [7:0]     cfg_w5 = 0, cfg_h5 = 0;
    logic [PW5-1:0] in_pixels5 = '0;
    logic           in_ready5, out_valid5, frame_done5, cfg_err5, busy5;
    logic [WW5-1:0] out_window5;

    conv_window_streamer #(.BITSIZE(B), .CHANNELS(CH), .KSIZE(K), .MAX_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_stride2(cfg_stride2), .in_valid(in_valid),
        .in_ready(in_ready), .in_pixels(in_pixels), .out_valid(out_valid),
        .out_ready(out_ready), .out_window(out_window), .frame_done(frame_done),
        .cfg_err(cfg_err), .busy(busy));

    conv_window_streamer #(.BITSIZE(B), .CHANNELS(CH5), .KSIZE(K5), .MAX_WIDTH(MW)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .flush(flush5), .cfg_width(cfg_w5),
        .cfg_height(cfg_h5), .cfg_stride2(stride5), .in_valid(in_valid5),
        .in_ready(in_ready5), .in_pixels(in_pixels5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_window(out_window5), .frame_done(frame_done5),
        .cfg_err(cfg_err5), .busy(busy5));

    int checks = 0;
    int failures = 0;

    logic [PW-1:0]  px [0:4095];
    exp_t           exp_q[$];
    logic [WW-1:0]  got_log[$];
    logic [WW5-1:0] exp5_q[$];
    logic [WW5-1:0] first5;
    int             win5_cnt = 0, done5_cnt = 0;
    int             beats_seen = 0, done_cnt = 0;
    bit             hs_prev = 0, hold_prev = 0, expect_hs_done = 0, rdy_rand = 0;
    logic [WW-1:0]  hold_win;
    exp_t           mon_e;
    logic [WW5-1:0] mon_e5;
    int             bad, bad5;
    int             first_taps[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int             s2_corner[4]  = '{0, 2, 16, 18};

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Scoreboard monitor for the KSIZE=3 instance
    always @(negedge clk) begin
        if (rst) begin
            if (hold_prev) begin
                check("hold_valid", out_valid == 1'b1, out_valid, 1);
                check("hold_window", out_window == hold_win, out_window[63:0], hold_win[63:0]);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready == 1'b0, in_ready, 0);
            if (frame_done) begin
                done_cnt++;
                if (expect_hs_done) check("done_after_last_hs", hs_prev, hs_prev, 1);
            end
            hs_prev = 0;
            if (out_valid && out_ready) begin
                hs_prev = 1;
                got_log.push_back(out_window);
                if (exp_q.size() == 0) begin
                    check("unexpected_window", 1'b0, 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    bad = -1;
                    for (int t = 0; t < CH * K * K; t++)
                        if (bad < 0 && out_window[t*B +: B] !== mon_e.win[t*B +: B]) bad = t;
                    if (bad < 0) bad5 = 0; else bad5 = bad;
                    check($sformatf("window_tap%0d", bad5), bad < 0,
                          longint'(out_window[bad5*B +: B]), longint'(mon_e.win[bad5*B +: B]));
                    check("window_after_beat", beats_seen >= mon_e.idx + 1, beats_seen, mon_e.idx + 1);
                end
            end
            if (in_valid && in_ready) beats_seen++;
            hold_prev = out_valid && !out_ready;
            hold_win  = out_window;
        end else begin
            hs_prev   = 0;
            hold_prev = 0;
        end
    end

    // Scoreboard monitor for the KSIZE=5 instance
    always @(negedge clk) begin
        if (rst) begin
            if (frame_done5) done5_cnt++;
            if (out_valid5 && out_ready5) begin
                if (win5_cnt == 0) first5 = out_window5;
                win5_cnt++;
                if (exp5_q.size() == 0) begin
                    check("k5_unexpected_window", 1'b0, 1, 0);
                end else begin
                    mon_e5 = exp5_q.pop_front();
                    bad = -1;
                    for (int t = 0; t < CH5 * K5 * K5; t++)
                        if (bad < 0 && out_window5[t*B +: B] !== mon_e5[t*B +: B]) bad = t;
                    if (bad < 0) bad5 = 0; else bad5 = bad;
                    check($sformatf("k5_window_tap%0d", bad5), bad < 0,
                          longint'(out_window5[bad5*B +: B]), longint'(mon_e5[bad5*B +: B]));
                end
            end
        end
    end

    task automatic load_frame(input int w, input int h, input bit rnd);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int ch = 0; ch < CH; ch++)
                    px[r*w + c][ch*B +: B] = rnd ? B'($urandom) : B'(100*ch + 8*r + c);
    endtask

    // Reference: every top-left corner on the stride grid, in raster order
    task automatic push_expected(input int w, input int h, input bit s2);
        int s;
        s = s2 ? 2 : 1;
        for (int i = 0; i <= (h - K) / s; i++) begin
            for (int j = 0; j <= (w - K) / s; j++) begin
                exp_t e;
                for (int ch = 0; ch < CH; ch++)
                    for (int r = 0; r < K; r++)
                        for (int k = 0; k < K; k++)
                            e.win[(ch*K*K + r*K + k)*B +: B] = px[(i*s + r)*w + j*s + k][ch*B +: B];
                e.idx = (i*s + K - 1)*w + j*s + K - 1;
                exp_q.push_back(e);
            end
        end
        expect_hs_done = ((h - K) % s == 0) && ((w - K) % s == 0);
    endtask

    task automatic run_frame(input int w, input int h, input bit s2, input bit rnd_pix,
                             input bit rnd_valid, input int abort_after);
        int n, i, guard, d0;
        bit acc;
        n = w * h;
        i = 0;
        guard = 0;
        load_frame(w, h, rnd_pix);
        if (abort_after == 0) push_expected(w, h, s2);
        got_log.delete();
        beats_seen = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_stride2 = s2; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_in_run", busy == 1'b1, busy, 1);
        while (i < n && guard < 20000) begin
            if (abort_after > 0 && i == abort_after) break;
            in_valid  = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_pixels = px[i];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 0;
        check("beats_accepted", i == ((abort_after > 0) ? abort_after : n), i,
              (abort_after > 0) ? abort_after : n);
        if (abort_after > 0) begin
            flush = 1;
            @(posedge clk); #1;
            flush = 0;
            check("flush_out_valid", out_valid == 1'b0, out_valid, 0);
            check("flush_busy", busy == 1'b0, busy, 0);
            repeat (5) @(posedge clk);
            #1;
            check("flush_no_done", done_cnt == d0, done_cnt - d0, 0);
        end else begin
            guard = 0;
            while (done_cnt == d0 && guard < 500) begin
                @(posedge clk); #1;
                guard++;
            end
            check("frame_done_seen", done_cnt == d0 + 1, done_cnt - d0, 1);
            check("all_windows_out", exp_q.size() == 0, exp_q.size(), 0);
            @(posedge clk); #1;
            check("idle_after_done", busy == 1'b0, busy, 0);
            check("single_done_pulse", done_cnt == d0 + 1, done_cnt - d0, 1);
        end
    endtask

    task automatic bad_start(input int w, input int h);
        @(posedge clk); #1;
        cfg_width = 8'(w); cfg_height = 8'(h); start = 1;
        @(posedge clk); #1;
        start = 0;
        check($sformatf("cfg_err_w%0d_h%0d", w, h), cfg_err == 1'b1, cfg_err, 1);
        check("cfg_err_busy", busy == 1'b0, busy, 0);
        @(posedge clk); #1;
        check("cfg_err_pulse", cfg_err == 1'b0, cfg_err, 0);
    endtask

    initial begin
        logic [WW-1:0] w0;
        int i, guard;
        bit acc;

        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready == 1'b0, in_ready, 0);
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_out_window", out_window == '0, out_window[63:0], 0);
        check("rst_frame_done", frame_done == 1'b0, frame_done, 0);
        check("rst_cfg_err", cfg_err == 1'b0, cfg_err, 0);
        check("rst_busy", busy == 1'b0, busy, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(5, 5, 0, 0, 0, 0);
        check("t1_window_count", got_log.size() == 9, got_log.size(), 9);
        if (got_log.size() > 0) begin
            w0 = got_log[0];
            for (int t = 0; t < 9; t++)
                check($sformatf("t1_ch0_tap%0d", t), int'(w0[t*B +: B]) == first_taps[t],
                      w0[t*B +: B], first_taps[t]);
            check("t1_ch1_tap0", int'(w0[K*K*B +: B]) == 100, w0[K*K*B +: B], 100);
        end

        run_frame(5, 5, 1, 0, 0, 0);
        check("t2_window_count", got_log.size() == 4, got_log.size(), 4);
        for (int n = 0; n < 4; n++) begin
            if (n < got_log.size()) begin
                w0 = got_log[n];
                check($sformatf("t2_corner%0d", n), int'(w0[B-1:0]) == s2_corner[n],
                      w0[B-1:0], s2_corner[n]);
            end
        end

        rdy_rand = 1;
        run_frame(5, 5, 0, 0, 0, 0);
        check("t3_window_count", got_log.size() == 9, got_log.size(), 9);
        rdy_rand = 0;

        bad_start(2, 5);
        bad_start(MW + 1, 5);
        bad_start(5, 2);

        run_frame(5, 5, 0, 0, 0, 12);
        run_frame(5, 5, 0, 0, 0, 0);
        check("after_flush_count", got_log.size() == 9, got_log.size(), 9);

        rdy_rand = 1;
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(3, 12), $urandom_range(3, 10), 1'($urandom_range(0, 1)), 1, 1, 0);
        rdy_rand = 0;

        load_frame(5, 5, 0);
        @(posedge clk); #1;
        cfg_width = 5; cfg_height = 5; cfg_stride2 = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        i = 0;
        guard = 0;
        while (i < 13 && guard < 200) begin
            in_valid = 1; in_pixels = px[i];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        rst = 0;
        #1;
        check("arst_in_ready", in_ready == 1'b0, in_ready, 0);
        check("arst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("arst_out_window", out_window == '0, out_window[63:0], 0);
        check("arst_busy", busy == 1'b0, busy, 0);
        check("arst_frame_done", frame_done == 1'b0, frame_done, 0);
        exp_q.delete();
        in_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("arst_stays_idle", busy == 1'b0, busy, 0);
        run_frame(5, 5, 1, 1, 1, 0);

        for (int wi = 0; wi <= 1; wi++)
            for (int wj = 0; wj <= 2; wj++) begin
                logic [WW5-1:0] e5;
                for (int c = 0; c < CH5; c++)
                    for (int r = 0; r < K5; r++)
                        for (int k = 0; k < K5; k++)
                            e5[(c*K5*K5 + r*K5 + k)*B +: B] = B'(100*c + 8*(wi + r) + wj + k);
                exp5_q.push_back(e5);
            end
        @(posedge clk); #1;
        cfg_w5 = 7; cfg_h5 = 6; start5 = 1;
        @(posedge clk); #1;
        start5 = 0;
        i = 0;
        guard = 0;
        while (i < 42 && guard < 2000) begin
            in_valid5 = 1;
            for (int c = 0; c < CH5; c++) in_pixels5[c*B +: B] = B'(100*c + 8*(i / 7) + i % 7);
            @(negedge clk);
            acc = in_valid5 && in_ready5;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid5 = 0;
        guard = 0;
        while (done5_cnt == 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("k5_frame_done", done5_cnt == 1, done5_cnt, 1);
        check("k5_window_count", win5_cnt == 6, win5_cnt, 6);
        check("k5_queue_empty", exp5_q.size() == 0, exp5_q.size(), 0);
        if (win5_cnt > 0) begin
            for (int k = 0; k < K5; k++) begin
                check($sformatf("k5_row0_tap%0d", k), int'(first5[k*B +: B]) == k, first5[k*B +: B], k);
                check($sformatf("k5_row4_tap%0d", k), int'(first5[(20 + k)*B +: B]) == 32 + k,
                      first5[(20 + k)*B +: B], 32 + k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
